// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: time-step controller for the excitatory SNN layer.
// For each time step it walks the shared synapse path over all inputs, then
// strobes neuron update, samples the spike vector, and (if anything fired)
// strobes learning. It counts spikes per neuron across the run and reports
// the winning neuron at the end.
// Optional build macro SNN_WTA_INH_EN: winner-take-all learning strobe plus
// lateral inhibition pulse. Without it spike_inh is tied low and learn_en
// carries the full spike vector.
module snn_step_scheduler #(
  parameter int INPUTNUM = 10,
  parameter int EXCNUM   = 2,
  parameter int STEP_W   = 8,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1,
  localparam int WIN_W   = (EXCNUM > 1) ? $clog2(EXCNUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  syn_idx,
  output logic              syn_valid,
  output logic              neuron_en,
  input  logic [EXCNUM-1:0] exc_spikes,
  output logic [EXCNUM-1:0] learn_en,
  output logic              spike_inh,
  output logic [STEP_W-1:0] step_cnt,
  output logic [WIN_W-1:0]  winner,
  output logic              winner_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    FIRE   = 3'd2,
    SAMPLE = 3'd3,
    LEARN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUTNUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_reg;
  logic [STEP_W-1:0]   steps_reg;
  logic [STEP_W-1:0]   step_cnt_reg;
  logic [IDX_W-1:0]    syn_idx_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                syn_valid_reg;
  logic                neuron_en_reg;
  logic [EXCNUM-1:0]   learn_en_reg;
  logic [WIN_W-1:0]    winner_reg;
  logic                winner_valid_reg;

  logic [CNT_W-1:0]    cnt_reg  [EXCNUM];
  logic [CNT_W-1:0]    cnt_next [EXCNUM];

  logic                accept_start;
  logic                sample_now;
  logic                any_spike;
  logic                step_end;
  logic                last_step;
  logic [EXCNUM-1:0]   learn_vec;
  logic [WIN_W-1:0]    win_idx;
  logic [CNT_W-1:0]    win_max;
  logic                any_nz;

  assign accept_start = en && (state_reg == IDLE) && start;
  assign sample_now   = en && (state_reg == SAMPLE);
  assign any_spike    = |exc_spikes;
  // A step finishes after SAMPLE when nothing fired, otherwise after LEARN.
  assign step_end     = ((state_reg == SAMPLE) && !any_spike) || (state_reg == LEARN);
  assign last_step    = (step_cnt_reg == (steps_reg - STEP_W'(1)));

`ifdef SNN_WTA_INH_EN
  logic spike_inh_reg;

  // Lowest set bit of the spike vector: two's complement isolates it.
  assign learn_vec = exc_spikes & (~exc_spikes + EXCNUM'(1));

  // Inhibition covers the LEARN cycle and the first ACCUM cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_inh_reg <= 1'b0;
    end else if (en) begin
      if (state_reg == SAMPLE) begin
        spike_inh_reg <= any_spike;
      end else if (state_reg == LEARN) begin
        spike_inh_reg <= !last_step;
      end else begin
        spike_inh_reg <= 1'b0;
      end
    end
  end

  assign spike_inh = spike_inh_reg;
`else
  assign learn_vec = exc_spikes;
  assign spike_inh = 1'b0;
`endif

  // Per-neuron saturating spike counters, cleared on every accepted start.
  generate
    for (genvar gi = 0; gi < EXCNUM; gi++) begin : g_cnt
      assign cnt_next[gi] = (sample_now && exc_spikes[gi] && (cnt_reg[gi] != CNT_MAX))
                            ? cnt_reg[gi] + CNT_W'(1) : cnt_reg[gi];

      // Counter update: clear at run start, count in SAMPLE.
      always_ff @(posedge clk) begin
        if (rst || accept_start) begin
          cnt_reg[gi] <= '0;
        end else if (sample_now) begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  // Argmax over the post-update counts; strict compare keeps the lowest index on ties.
  always_comb begin
    win_idx = '0;
    win_max = cnt_next[0];
    any_nz  = 1'b0;
    for (int i = 0; i < EXCNUM; i++) begin
      if (cnt_next[i] != '0) begin
        any_nz = 1'b1;
      end
      if (cnt_next[i] > win_max) begin
        win_max = cnt_next[i];
        win_idx = WIN_W'(i);
      end
    end
  end

  // Main sequencer: state plus all registered outputs, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      steps_reg        <= '0;
      step_cnt_reg     <= '0;
      syn_idx_reg      <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      syn_valid_reg    <= 1'b0;
      neuron_en_reg    <= 1'b0;
      learn_en_reg     <= '0;
      winner_reg       <= '0;
      winner_valid_reg <= 1'b0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg         <= 1'b1;
            steps_reg        <= num_steps;
            step_cnt_reg     <= '0;
            syn_idx_reg      <= '0;
            winner_reg       <= '0;
            winner_valid_reg <= 1'b0;
            if (num_steps != '0) begin
              syn_valid_reg <= 1'b1;
              state_reg     <= ACCUM;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        ACCUM: begin
          if (syn_idx_reg == IDX_LAST) begin
            syn_valid_reg <= 1'b0;
            neuron_en_reg <= 1'b1;
            state_reg     <= FIRE;
          end else begin
            syn_idx_reg <= syn_idx_reg + IDX_W'(1);
          end
        end
        FIRE: begin
          neuron_en_reg <= 1'b0;
          state_reg     <= SAMPLE;
        end
        SAMPLE: begin
          if (any_spike) begin
            learn_en_reg <= learn_vec;
            state_reg    <= LEARN;
          end
        end
        LEARN: begin
          learn_en_reg <= '0;
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Shared step-end decision; overrides the next state chosen above.
      if (step_end) begin
        if (last_step) begin
          done_reg         <= 1'b1;
          winner_reg       <= win_idx;
          winner_valid_reg <= any_nz;
          state_reg        <= DONE;
        end else begin
          step_cnt_reg  <= step_cnt_reg + STEP_W'(1);
          syn_idx_reg   <= '0;
          syn_valid_reg <= 1'b1;
          state_reg     <= ACCUM;
        end
      end
    end
  end

  // Strobes come from registers and are qualified by en so a frozen cycle
  // neither drops nor repeats a pulse.
  assign busy         = busy_reg;
  assign done         = done_reg & en;
  assign syn_valid    = syn_valid_reg & en;
  assign neuron_en    = neuron_en_reg & en;
  assign learn_en     = learn_en_reg & {EXCNUM{en}};
  assign syn_idx      = syn_idx_reg;
  assign step_cnt     = step_cnt_reg;
  assign winner       = winner_reg;
  assign winner_valid = winner_valid_reg;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed testbench for snn_step_scheduler (INPUTNUM=10, EXCNUM=2, CNT_W=8).
// STEP_W is widened to 9 so a single run can deliver 300 spikes to a neuron.
module tb_snn_step_scheduler;

  localparam int INPUTNUM = 10;
  localparam int EXCNUM   = 2;
  localparam int STEP_W   = 9;
  localparam int CNT_W    = 8;
  localparam int NONE     = 1000000;

  logic              clk;
  logic              rst;
  logic              en;
  logic              start;
  logic [STEP_W-1:0] num_steps;
  logic              busy;
  logic              done;
  logic [3:0]        syn_idx;
  logic              syn_valid;
  logic              neuron_en;
  logic [EXCNUM-1:0] exc_spikes;
  logic [EXCNUM-1:0] learn_en;
  logic              spike_inh;
  logic [STEP_W-1:0] step_cnt;
  logic [0:0]        winner;
  logic              winner_valid;

  int checks;
  int failures;

  int r_done_cyc, r_first_fire, r_fire, r_valid, r_idx_err, r_learn, r_inh;
  int r_busy_low, r_resume_idx, r_step_at_done, r_busy_after;
  logic [EXCNUM-1:0] r_learn_or;
  logic r_off_strobe, r_winner, r_wv;

  snn_step_scheduler #(
    .INPUTNUM(INPUTNUM),
    .EXCNUM  (EXCNUM),
    .STEP_W  (STEP_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .num_steps   (num_steps),
    .busy        (busy),
    .done        (done),
    .syn_idx     (syn_idx),
    .syn_valid   (syn_valid),
    .neuron_en   (neuron_en),
    .exc_spikes  (exc_spikes),
    .learn_en    (learn_en),
    .spike_inh   (spike_inh),
    .step_cnt    (step_cnt),
    .winner      (winner),
    .winner_valid(winner_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start (num_steps and exc_spikes preset by caller), then steps the
  // clock until done, applying the optional mid-run events and recording
  // what the DUT emitted. Cycle n is the cycle after the n-th edge.
  task automatic run_measure(input string name, input int chg_cyc, input logic [1:0] chg_val,
                             input int en_off_cyc, input int start_cyc);
    int cyc;
    int exp_idx;
    bit fin;
    r_done_cyc = -1; r_first_fire = -1; r_fire = 0; r_valid = 0; r_idx_err = 0;
    r_learn = 0; r_inh = 0; r_busy_low = 0; r_resume_idx = -1; r_step_at_done = -1;
    r_busy_after = -1; r_learn_or = '0; r_off_strobe = 1'b0; r_winner = 1'b0; r_wv = 1'b0;
    start = 1'b1;
    cyc = 0;
    exp_idx = 0;
    fin = 1'b0;
    while (!fin && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == chg_cyc) exc_spikes = chg_val;
      if (cyc == en_off_cyc) en = 1'b0;
      if (cyc == en_off_cyc + 5) en = 1'b1;
      if (cyc == start_cyc) begin
        start = 1'b1;
        num_steps = num_steps + STEP_W'(4);
      end
      if (cyc == start_cyc + 1) start = 1'b0;
      #1;
      if (!en) r_off_strobe = r_off_strobe | syn_valid | neuron_en | (|learn_en) | done;
      if (cyc == en_off_cyc + 5) r_resume_idx = int'(syn_idx);
      if (syn_valid) begin
        r_valid++;
        if (int'(syn_idx) != exp_idx) r_idx_err++;
        exp_idx = (exp_idx + 1) % INPUTNUM;
      end
      if (neuron_en) begin
        r_fire++;
        if (r_first_fire < 0) r_first_fire = cyc;
      end
      if (learn_en != '0) begin
        r_learn++;
        r_learn_or = r_learn_or | learn_en;
      end
      if (spike_inh) r_inh++;
      if (!busy) r_busy_low++;
      if (done) begin
        r_done_cyc = cyc;
        r_step_at_done = int'(step_cnt);
        r_winner = winner;
        r_wv = winner_valid;
        fin = 1'b1;
      end
    end
    check({name, "_timeout"}, 32'(fin), 32'd1);
    @(posedge clk);
    #2;
    r_busy_after = int'(busy);
    $display("run %s: done_cycle=%0d fires=%0d valid=%0d learns=%0d learn_or=%b inh=%0d step=%0d winner=%0d wv=%0b",
             name, r_done_cyc, r_fire, r_valid, r_learn, r_learn_or, r_inh, r_step_at_done,
             r_winner, r_wv);
  endtask

  initial begin
    int done_seen;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    num_steps = '0;
    exc_spikes = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_syn_valid", 32'(syn_valid), 32'd0);
    check("rst_neuron_en", 32'(neuron_en), 32'd0);
    check("rst_learn_en", 32'(learn_en), 32'd0);
    check("rst_spike_inh", 32'(spike_inh), 32'd0);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    check("rst_syn_idx", 32'(syn_idx), 32'd0);
    check("rst_winner", {31'd0, winner_valid, winner}, 32'd0);

    // R1: one step, no spikes: 10 indices, fire at 11, done at 13
    num_steps = 9'd1;
    exc_spikes = 2'b00;
    run_measure("r1", NONE, 2'b00, NONE, NONE);
    check("r1_done_cyc", r_done_cyc, 32'd13);
    check("r1_first_fire", r_first_fire, 32'd11);
    check("r1_fires", r_fire, 32'd1);
    check("r1_valid", r_valid, 32'd10);
    check("r1_idx_err", r_idx_err, 32'd0);
    check("r1_wv", 32'(r_wv), 32'd0);
    check("r1_busy_low", r_busy_low, 32'd0);
    check("r1_busy_after", r_busy_after, 32'd0);

    // R2: three steps, neuron1 spikes every step: 13 cycles/step
    num_steps = 9'd3;
    exc_spikes = 2'b10;
    run_measure("r2", NONE, 2'b00, NONE, NONE);
    check("r2_done_cyc", r_done_cyc, 32'd40);
    check("r2_learns", r_learn, 32'd3);
    check("r2_learn_or", 32'(r_learn_or), 32'd2);
    check("r2_step", r_step_at_done, 32'd2);
    check("r2_winner", 32'(r_winner), 32'd1);
    check("r2_wv", 32'(r_wv), 32'd1);
`ifdef SNN_WTA_INH_EN
    check("r2_inh", r_inh, 32'd5);
`else
    check("r2_inh", r_inh, 32'd0);
`endif

    // R3: both neurons spike in step 0 only: tie, lowest index wins
    num_steps = 9'd2;
    exc_spikes = 2'b11;
    run_measure("r3", 14, 2'b00, NONE, NONE);
    check("r3_done_cyc", r_done_cyc, 32'd26);
    check("r3_learns", r_learn, 32'd1);
    check("r3_winner", 32'(r_winner), 32'd0);
    check("r3_wv", 32'(r_wv), 32'd1);
`ifdef SNN_WTA_INH_EN
    check("r3_learn_or", 32'(r_learn_or), 32'd1);
    check("r3_inh", r_inh, 32'd2);
`else
    check("r3_learn_or", 32'(r_learn_or), 32'd3);
    check("r3_inh", r_inh, 32'd0);
`endif

    // R4: en low for 5 cycles while syn_idx=4
    num_steps = 9'd1;
    exc_spikes = 2'b00;
    run_measure("r4", NONE, 2'b00, 5, NONE);
    check("r4_done_cyc", r_done_cyc, 32'd18);
    check("r4_resume_idx", r_resume_idx, 32'd4);
    check("r4_off_strobe", 32'(r_off_strobe), 32'd0);
    check("r4_valid", r_valid, 32'd10);
    check("r4_idx_err", r_idx_err, 32'd0);
    check("r4_fires", r_fire, 32'd1);

    // R5: reset in the middle of step 2 ACCUM (cycle 28, syn_idx=3)
    num_steps = 9'd3;
    exc_spikes = 2'b00;
    start = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      #1;
    end
    check("r5_pre_step", 32'(step_cnt), 32'd2);
    check("r5_pre_idx", 32'(syn_idx), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("r5_busy", 32'(busy), 32'd0);
    check("r5_syn_valid", 32'(syn_valid), 32'd0);
    check("r5_step_cnt", 32'(step_cnt), 32'd0);
    done_seen = 0;
    if (done) done_seen++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (done) done_seen++;
    end
    check("r5_no_done", done_seen, 32'd0);
    $display("run r5: reset mid-run step=%0d busy=%0b", step_cnt, busy);

    // R5b: num_steps=0 goes straight to DONE
    num_steps = 9'd0;
    run_measure("r5b", NONE, 2'b00, NONE, NONE);
    check("r5b_done_cyc", r_done_cyc, 32'd1);
    check("r5b_wv", 32'(r_wv), 32'd0);
    check("r5b_valid", r_valid, 32'd0);
    check("r5b_busy_after", r_busy_after, 32'd0);

    // R6: start pulsed (with new num_steps) while busy is ignored
    num_steps = 9'd2;
    exc_spikes = 2'b00;
    run_measure("r6", NONE, 2'b00, NONE, 5);
    check("r6_done_cyc", r_done_cyc, 32'd25);
    check("r6_step", r_step_at_done, 32'd1);
    check("r6_fires", r_fire, 32'd2);

    // R7: n1 300 spikes (saturates at 255), n0 255 spikes: tie -> winner 0
    num_steps = 9'd300;
    exc_spikes = 2'b11;
    run_measure("r7", 255 * 13 + 5, 2'b10, NONE, NONE);
    check("r7_done_cyc", r_done_cyc, 32'd3901);
    check("r7_learns", r_learn, 32'd300);
    check("r7_winner", 32'(r_winner), 32'd0);
    check("r7_wv", 32'(r_wv), 32'd1);

    // R8: n1 300 spikes (saturates at 255), n0 100 spikes -> winner 1
    num_steps = 9'd300;
    exc_spikes = 2'b11;
    run_measure("r8", 100 * 13 + 5, 2'b10, NONE, NONE);
    check("r8_done_cyc", r_done_cyc, 32'd3901);
    check("r8_winner", 32'(r_winner), 32'd1);
    check("r8_step", r_step_at_done, 32'd299);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
